passcode_lock_ctrl: RTL and testbench
=====================================

PASSCODE_LOCK_CTRL -- requirements
Module: passcode_lock_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 3, number of entries per passcode (1..8).
REQ-002 Parameter DIGIT_W, default 8, entry width: DIGIT_W/4 BCD nibbles per entry; DIGIT_W SHALL be a multiple of 4.
REQ-003 Parameter PASSCODE, default 24'h123456, reset passcode, NUM_DIGITS*DIGIT_W bits, entry 0 in MSBs.
REQ-004 Parameter MAX_TRIES, default 3, consecutive failures that trigger lockout (>=1).
REQ-005 Parameter LOCKOUT_CYCLES, default 50_000_000, lockout duration in clk cycles (>=1).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 sw  input  DIGIT_W  BCD entry value from switches.
REQ-009 push  input  1  debounced button level; an action is its rising edge only.
REQ-010 prog  input  1  program-mode select, sampled on a push edge in OPEN.
REQ-011 state  output  3  current state: ENTRY=0, CHECK=1, FAIL=2, OPEN=3, PROG=4, LOCKOUT=5.
REQ-012 digit_idx  output  3  index of the next entry to be captured.
REQ-013 fail_cnt  output  4  consecutive failed attempts.
REQ-014 unlocked  output  1  high exactly while state==OPEN or PROG.
REQ-015 lockout  output  1  high exactly while state==LOCKOUT.
REQ-016 err  output  1  one-cycle pulse on rejected entry or failed check.

Function
REQ-017 push_edge = push & ~push_q, push_q a register of push; all actions below occur only on push_edge.
REQ-018 Entry validity: any nibble of sw >9 is invalid; an invalid entry is not stored, digit_idx unchanged, err pulses the next cycle.
REQ-019 ENTRY: valid push_edge stores sw into buffer slot digit_idx, digit_idx+1; on storing slot NUM_DIGITS-1, digit_idx->0, state->CHECK.
REQ-020 CHECK: lasts exactly one cycle; full buffer compared with code register.
REQ-021 CHECK match -> OPEN, fail_cnt->0.
REQ-022 CHECK mismatch: err pulse, fail_cnt+1; if new fail_cnt==MAX_TRIES -> LOCKOUT, else -> FAIL.
REQ-023 FAIL: held until next push_edge, which is consumed (not stored) and returns to ENTRY with buffer cleared to all-ones.
REQ-024 OPEN: push_edge with prog=0 -> ENTRY, buffer cleared; push_edge with prog=1 -> PROG, digit_idx->0.
REQ-025 PROG: valid push_edges fill the buffer as in ENTRY; after slot NUM_DIGITS-1 the code register loads the full buffer in one cycle and state->OPEN; invalid entries rejected per REQ-018.
REQ-026 LOCKOUT: down-counter loaded with LOCKOUT_CYCLES-1 on entry, decrements each cycle; all push edges ignored; at 0 -> ENTRY, fail_cnt->0, buffer cleared.
REQ-027 fail_cnt saturates at MAX_TRIES; never wraps.
REQ-028 Code register changes only at PROG completion; a push edge arriving in CHECK is ignored.
REQ-029 Latency: final valid entry edge -> CHECK next cycle -> OPEN/FAIL/LOCKOUT the cycle after.

Reset
REQ-030 On rst: state=ENTRY, digit_idx=0, fail_cnt=0, unlocked=0, lockout=0, err=0, buffer all-ones, code register=PASSCODE, lockout counter=0.
REQ-031 push_q resets to 1 so a button held through reset release produces no action.
REQ-032 rst asserted mid-operation (any state, incl. PROG partially filled) aborts it; code register reverts to PASSCODE.

Verification (NUM_DIGITS=3, DIGIT_W=8, PASSCODE=24'h123456, MAX_TRIES=3, LOCKOUT_CYCLES=16)
REQ-033 Pushes with sw=12,34,56 -> CHECK one cycle, then state=3, unlocked=1, fail_cnt=0.
REQ-034 Three wrong codes (11,11,11 each, FAIL cleared by push between) -> err pulse each, fail_cnt 1,2,3, third -> state=5, lockout=1 for exactly 16 cycles, pushes ignored, then state=0, fail_cnt=0.
REQ-035 sw=8'h1A pushed in ENTRY -> err pulse, digit_idx stays 0; then 12,34,56 -> OPEN.
REQ-036 In OPEN prog=1 push, then 98,76,54 -> OPEN; prog=0 push -> ENTRY; 12,34,56 fails; 98,76,54 opens; rst -> 12,34,56 opens again.
REQ-037 push held high across rst release, then held 10 cycles -> no entry stored, digit_idx=0; release and push again -> one entry stored.
REQ-038 Two entries then rst -> state=0, digit_idx=0, buffer all-ones, all outputs at reset values.

Source files
------------

// File: rtl/passcode_lock_ctrl.sv
// Passcode lock: BCD entries captured on push rising edges, checked against a programmable code, lockout after repeated failures.
// Latency: last entry edge -> CHECK next cycle -> result the cycle after; no backpressure, edges outside ENTRY/PROG/FAIL/OPEN are dropped.
module passcode_lock_ctrl #(
  parameter int NUM_DIGITS = 3,
  parameter int DIGIT_W = 8,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASSCODE = 24'h123456,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               push,
  input  logic               prog,
  output logic [2:0]         state,
  output logic [2:0]         digit_idx,
  output logic [3:0]         fail_cnt,
  output logic               unlocked,
  output logic               lockout,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_FAIL    = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int NIB = DIGIT_W / 4;
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] MAX_F = 4'(MAX_TRIES);
  localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               push_q;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         fail_q, fail_d, fail_inc;
  logic               err_q, err_d;
  logic [BUF_W-1:0]   buf_q, buf_d, buf_wr;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               push_edge;
  logic               entry_ok;

  assign push_edge = push & ~push_q;
  assign fail_inc  = (fail_q >= MAX_F) ? MAX_F : fail_q + 4'd1;

  always_comb begin
    entry_ok = 1'b1;
    for (int k = 0; k < NIB; k++) begin
      if (sw[4*k +: 4] > 4'd9) entry_ok = 1'b0;
    end
  end

  // Entry 0 lives in the MSBs of the buffer.
  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) buf_wr[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    buf_d   = buf_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ENTRY, ST_PROG: begin
        if (push_edge) begin
          if (!entry_ok) begin
            err_d = 1'b1;
          end else begin
            buf_d = buf_wr;
            if (idx_q == IDX_LAST) begin
              idx_d = 3'd0;
              if (state_q == ST_PROG) begin
                code_d  = buf_wr;
                state_d = ST_OPEN;
              end else begin
                state_d = ST_CHECK;
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      ST_CHECK: begin
        if (buf_q == code_q) begin
          state_d = ST_OPEN;
          fail_d  = 4'd0;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == MAX_F) begin
            state_d = ST_LOCKOUT;
            cnt_d   = LOCK_LOAD;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        if (push_edge) begin
          state_d = ST_ENTRY;
          buf_d   = '1;
        end
      end
      ST_OPEN: begin
        if (push_edge) begin
          if (prog) begin
            state_d = ST_PROG;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_ENTRY;
            buf_d   = '1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q == 32'd0) begin
          state_d = ST_ENTRY;
          fail_d  = 4'd0;
          idx_d   = 3'd0;
          buf_d   = '1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // push_q resets high so a button held across reset release is not an action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      push_q  <= 1'b1;
      idx_q   <= 3'd0;
      fail_q  <= 4'd0;
      err_q   <= 1'b0;
      buf_q   <= '1;
      code_q  <= PASSCODE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      push_q  <= push;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign digit_idx = idx_q;
  assign fail_cnt  = fail_q;
  assign unlocked  = (state_q == ST_OPEN) || (state_q == ST_PROG);
  assign lockout   = (state_q == ST_LOCKOUT);
  assign err       = err_q;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Bench for passcode_lock_ctrl: directed pushes, an entry-list model compared every cycle, plus literal expectations.
module tb_passcode_lock_ctrl;
  localparam int ND = 3;
  localparam int DW = 8;
  localparam int MT = 3;
  localparam int LC = 16;
  localparam int S_ENTRY = 0, S_CHECK = 1, S_FAIL = 2, S_OPEN = 3, S_PROG = 4, S_LOCK = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic prog = 1'b0;
  logic [DW-1:0] sw = '0;
  logic [2:0] state, digit_idx;
  logic [3:0] fail_cnt;
  logic unlocked, lockout, err;

  passcode_lock_ctrl #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .PASSCODE(24'h123456),
    .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .push(push), .prog(prog),
    .state(state), .digit_idx(digit_idx), .fail_cnt(fail_cnt),
    .unlocked(unlocked), .lockout(lockout), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lock_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the entries typed so far, the current code as a list of entries, and counters.
  int m_state, m_fails, m_lock;
  bit m_err, m_prev, m_live = 1'b0, m_edge;
  logic [7:0] m_q[$];
  logic [7:0] m_pend[$];
  logic [7:0] m_code[ND];

  function automatic bit bcd_ok(input logic [7:0] v);
    for (int k = 0; k < 2; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit code_match();
    if (m_pend.size() != ND) return 1'b0;
    for (int i = 0; i < ND; i++) if (m_pend[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = S_ENTRY; m_fails = 0; m_lock = 0; m_err = 0; m_prev = 1; m_live = 1;
      m_q.delete(); m_pend.delete();
      m_code[0] = 8'h12; m_code[1] = 8'h34; m_code[2] = 8'h56;
    end else begin
      m_edge = push && !m_prev;
      m_prev = push;
      m_err = 0;
      case (m_state)
        S_ENTRY, S_PROG: if (m_edge) begin
          if (!bcd_ok(sw)) m_err = 1;
          else begin
            m_q.push_back(sw);
            if (m_q.size() == ND) begin
              if (m_state == S_PROG) begin
                for (int i = 0; i < ND; i++) m_code[i] = m_q[i];
                m_state = S_OPEN;
              end else begin
                m_pend = m_q;
                m_state = S_CHECK;
              end
              m_q.delete();
            end
          end
        end
        S_CHECK: begin
          if (code_match()) begin
            m_state = S_OPEN; m_fails = 0;
          end else begin
            m_err = 1;
            m_fails = (m_fails + 1 > MT) ? MT : m_fails + 1;
            if (m_fails == MT) begin m_state = S_LOCK; m_lock = LC; end
            else m_state = S_FAIL;
          end
        end
        S_FAIL: if (m_edge) m_state = S_ENTRY;
        S_OPEN: if (m_edge) m_state = prog ? S_PROG : S_ENTRY;
        S_LOCK: begin
          m_lock--;
          if (m_lock == 0) begin m_state = S_ENTRY; m_fails = 0; end
        end
        default: m_state = S_ENTRY;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_state", int'(state), m_state);
      chk("m_digit_idx", int'(digit_idx), m_q.size());
      chk("m_fail_cnt", int'(fail_cnt), m_fails);
      chk("m_unlocked", int'(unlocked), int'(m_state == S_OPEN || m_state == S_PROG));
      chk("m_lockout", int'(lockout), int'(m_state == S_LOCK));
      chk("m_err", int'(err), int'(m_err));
    end
    if (lockout === 1'b1) lock_seen++;
  end

  task automatic press(input logic [7:0] v);
    @(negedge clk); sw = v; push = 1'b1;
    @(negedge clk); push = 1'b0;
  endtask

  task automatic enter3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    press(a); press(b); press(c);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; push = 1'b0; prog = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_idx"}, int'(digit_idx), 0);
    chk({tag, "_fail"}, int'(fail_cnt), 0);
    chk({tag, "_unlocked"}, int'(unlocked), 0);
    chk({tag, "_lockout"}, int'(lockout), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Correct code: CHECK for one cycle, then OPEN.
    enter3(8'h12, 8'h34, 8'h56);
    chk("ok_check", int'(state), 1);
    @(negedge clk);
    chk("ok_open", int'(state), 3);
    chk("ok_unlocked", int'(unlocked), 1);
    chk("ok_fail", int'(fail_cnt), 0);
    press(8'h00);
    chk("open_to_entry", int'(state), 0);

    // Three wrong codes lead to lockout.
    for (int t = 1; t <= 3; t++) begin
      enter3(8'h11, 8'h11, 8'h11);
      chk("wrong_check", int'(state), 1);
      @(negedge clk);
      chk("wrong_err", int'(err), 1);
      chk("wrong_fail_cnt", int'(fail_cnt), t);
      chk("wrong_state", int'(state), (t < 3) ? 2 : 5);
      if (t < 3) begin
        press(8'h00);
        chk("fail_cleared", int'(state), 0);
        chk("fail_edge_not_stored", int'(digit_idx), 0);
      end
    end
    chk("lock_flag", int'(lockout), 1);
    repeat (5) press(8'h12);
    chk("lock_still", int'(state), 5);
    chk("lock_push_ignored", int'(digit_idx), 0);
    for (int i = 0; i < 40 && state != 3'd0; i++) @(negedge clk);
    chk("lockout_exit", int'(state), 0);
    chk("lockout_len", lock_seen, 16);
    chk("lockout_fail_clr", int'(fail_cnt), 0);

    // Invalid BCD entry rejected.
    press(8'h1A);
    chk("bad_err", int'(err), 1);
    chk("bad_idx", int'(digit_idx), 0);
    enter3(8'h12, 8'h34, 8'h56);
    @(negedge clk);
    chk("after_bad_open", int'(state), 3);

    // Reprogram the code.
    prog = 1'b1;
    press(8'h00);
    chk("prog_state", int'(state), 4);
    chk("prog_unlocked", int'(unlocked), 1);
    prog = 1'b0;
    enter3(8'h98, 8'h76, 8'h54);
    chk("prog_done", int'(state), 3);
    press(8'h00);
    chk("prog_exit", int'(state), 0);
    enter3(8'h12, 8'h34, 8'h56);
    @(negedge clk);
    chk("old_code_fails", int'(state), 2);
    chk("old_code_cnt", int'(fail_cnt), 1);
    press(8'h00);
    enter3(8'h98, 8'h76, 8'h54);
    @(negedge clk);
    chk("new_code_opens", int'(state), 3);
    chk("new_code_cnt", int'(fail_cnt), 0);
    do_reset();
    rst = 1'b0;
    enter3(8'h12, 8'h34, 8'h56);
    @(negedge clk);
    chk("reset_restores_code", int'(state), 3);

    // Push held across reset release is not an action.
    @(negedge clk); rst = 1'b1; push = 1'b1; sw = 8'h12;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_idx", int'(digit_idx), 0);
    chk("held_state", int'(state), 0);
    push = 1'b0;
    @(negedge clk);
    press(8'h12);
    chk("held_then_push", int'(digit_idx), 1);

    // Partial entry aborted by reset.
    press(8'h34);
    chk("partial_idx", int'(digit_idx), 2);
    do_reset();
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    enter3(8'h12, 8'h34, 8'h56);
    @(negedge clk);
    chk("post_reset_open", int'(state), 3);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
